keccak_absorb_unit: RTL and testbench
=====================================

Name: keccak_absorb_unit

Overview:
- Streams message lanes into the Keccak state, XORing each 64-bit beat into the next rate lane.
- Requests a permutation whenever a full rate block has been absorbed.
- On the final beat, presents the state plus the in-block byte count to the downstream suffix_padder_unit.
- Sits between the message input interface and suffix_padder_unit / keccak permutation core.

Parameters:
- IN_WIDTH, 64, input beat width in bits; fixed equal to LANE_SIZE, one lane per beat.
- KEEP_WIDTH, 8, byte-enable width (IN_WIDTH/8).
- MAX_RATE_BYTES, 168, largest supported rate in bytes (SHAKE128); sizes the byte counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  pulse; clears state and counter, latches rate_i; accepted only in IDLE
- rate_i  in  RATE_WIDTH  rate in bits (1088, 1344, ...); multiple of 64
- msg_valid_i  in  1  beat valid
- msg_ready_o  out  1  beat accepted when valid&ready
- msg_data_i  in  IN_WIDTH  message lane, little-endian byte order
- msg_keep_i  in  KEEP_WIDTH  contiguous low-byte enables; all-ones unless msg_last_i
- msg_last_i  in  1  final beat of message; keep may be 0..all-ones
- perm_start_o  out  1  one-cycle pulse requesting permutation of state_array_o
- perm_done_i  in  1  permutation complete; state_array_i valid this cycle
- state_array_i  in  ROW_SIZE x COL_SIZE x LANE_SIZE  permuted state returned
- state_array_o  out  ROW_SIZE x COL_SIZE x LANE_SIZE  registered current state
- pad_valid_o  out  1  state_array_o and bytes_absorbed_o ready for padding
- pad_ready_i  in  1  downstream accepts padding request
- bytes_absorbed_o  out  BYTE_ABSORB_WIDTH  message bytes in current block (0..rate_bytes-1)
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: state all zeros; counter 0; FSM IDLE; msg_ready_o=0, perm_start_o=0, pad_valid_o=0, err_o=0. Reset mid-operation abandons the block immediately; no pulse emitted.
- Derived quantities:
  - rate_bytes = rate_q/8; rate_lanes = rate_q/64.
  - lane index = cnt[.. :3], mapped x = idx mod 5, y = idx / 5 (lane 16 -> x=1,y=3).
- FSM states IDLE, ABSORB, PERM_WAIT, PAD_HOLD.
- IDLE:
  - msg_ready_o=0.
  - start_i: zero state, cnt=0, latch rate_q; go to ABSORB next cycle.
- ABSORB:
  - msg_ready_o=1.
  - On handshake: state[x][y] ^= data masked by keep (disabled bytes contribute 0); cnt += popcount(keep).
  - If the new cnt == rate_bytes (full block): cnt <= 0, perm_start_o pulses the following cycle, go to PERM_WAIT, remembering msg_last as pending_last.
  - Else if msg_last_i: go to PAD_HOLD.
  - Result registered; one cycle beat-to-state latency.
- PERM_WAIT:
  - msg_ready_o=0.
  - On perm_done_i, load state_array_i.
  - If pending_last: go to PAD_HOLD with cnt=0 (message exactly filled the rate; padding goes in a fresh block). Else return to ABSORB.
  - perm_done_i in any other state is ignored.
- PAD_HOLD:
  - pad_valid_o=1; state_array_o and bytes_absorbed_o held stable.
  - On pad_ready_i: go to IDLE.
  - Downstream owns the final permutation.
- Empty message (first beat last with keep=0): PAD_HOLD with cnt=0, state zero.
- start_i outside IDLE is ignored.
- rate_i is sampled only at start_i.

Optional Feature:
- Macro: KECCAK_ABSORB_KEEP_CHECK_EN.
- Defined: err_o sets (sticky until rst or start_i) on any accepted beat where:
  - keep is non-contiguous, or
  - keep is non-all-ones without msg_last_i, or
  - rate_i at start_i is not a multiple of 64 or exceeds MAX_RATE_BYTES*8.
- The offending beat is still absorbed normally.
- Undefined: err_o tied to 0; no check logic.

Decomposition:
- keccak_pkg already provides ROW_SIZE, COL_SIZE, LANE_SIZE, RATE_WIDTH, BYTE_ABSORB_WIDTH.
- Add to keccak_pkg:
  - absorb_state_e enum (IDLE, ABSORB, PERM_WAIT, PAD_HOLD).
  - Function lane_index_to_xy.
  - Function keep_to_mask (8-bit keep to 64-bit byte mask).
- One natural sub-module: keccak_lane_xor, combinational; selects the lane by index and XORs the masked beat.

Test Plan:
- SHA3-256 rate, beats 0x1111..11 then last beat 0x22 keep=0x01
  -> lane[0][0]=0x1111..11, lane[1][0]=0x22, bytes_absorbed_o=9, pad_valid_o=1, no perm_start_o.
- SHA3-256 rate, 17 full beats, last on beat 17
  -> perm_start_o once, PERM_WAIT; after perm_done_i with state 0xA5.., PAD_HOLD with bytes_absorbed_o=0 and state 0xA5...
- SHAKE128 rate, 21 full beats then last beat keep=0xFF
  -> one permutation after beat 21; beat 22 XORs into lane[0][0]; bytes_absorbed_o=8.
- Empty message: start, last with keep=0 -> PAD_HOLD, all-zero state, bytes_absorbed_o=0; pad_ready_i returns to IDLE.
- Backpressure and reset:
  - msg_valid_i held during PERM_WAIT -> beat not consumed until return to ABSORB.
  - rst asserted in PERM_WAIT -> all outputs at reset values next cycle.
- With KECCAK_ABSORB_KEEP_CHECK_EN:
  - keep=0x05 -> err_o=1 and stays 1.
  - start_i clears err_o.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak geometry, absorb FSM encoding and small lane helpers.
// Used by keccak_absorb_unit and keccak_lane_xor.
package keccak_pkg;

    localparam int ROW_SIZE          = 5;
    localparam int COL_SIZE          = 5;
    localparam int LANE_SIZE         = 64;
    localparam int RATE_WIDTH        = 11;
    localparam int BYTE_ABSORB_WIDTH = 8;
    localparam int LANE_IDX_WIDTH    = 5;
    localparam int LANE_BYTES        = LANE_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ABSORB    = 2'd1,
        PERM_WAIT = 2'd2,
        PAD_HOLD  = 2'd3
    } absorb_state_e;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    // Linear rate-lane index to state coordinates: x = idx mod 5, y = idx / 5.
    function automatic lane_xy_t lane_index_to_xy(input logic [LANE_IDX_WIDTH-1:0] idx);
        lane_xy_t xy;
        xy.x = 3'(idx % LANE_IDX_WIDTH'(ROW_SIZE));
        xy.y = 3'(idx / LANE_IDX_WIDTH'(ROW_SIZE));
        return xy;
    endfunction

    // Expand per-byte enables into a lane-wide bit mask.
    function automatic logic [LANE_SIZE-1:0] keep_to_mask(input logic [LANE_BYTES-1:0] keep);
        logic [LANE_SIZE-1:0] mask;
        mask = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

    // Number of enabled bytes in a beat.
    function automatic logic [3:0] keep_popcount(input logic [LANE_BYTES-1:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            cnt = cnt + 4'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keccak_absorb_unit_lane_xor.sv
// keccak_lane_xor: combinational XOR of one masked message beat into the
// addressed rate lane; all other lanes pass through untouched.
module keccak_lane_xor
    import keccak_pkg::*;
(
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_i,
    input  logic [LANE_IDX_WIDTH-1:0]                        lane_idx_i,
    input  logic [LANE_SIZE-1:0]                             data_i,
    input  logic [LANE_BYTES-1:0]                            keep_i,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_o
);

    lane_xy_t xy;

    // Select lane (x,y) from the byte counter and fold in the enabled bytes.
    always_comb begin
        state_o = state_i;
        xy      = lane_index_to_xy(lane_idx_i);
        if (lane_idx_i < LANE_IDX_WIDTH'(ROW_SIZE * COL_SIZE)) begin
            state_o[xy.x][xy.y] = state_i[xy.x][xy.y] ^ (data_i & keep_to_mask(keep_i));
        end
    end

endmodule

// File: rtl/keccak_absorb_unit.sv
// keccak_absorb_unit: streams 64-bit message lanes into the Keccak state,
// requests a permutation per full rate block, and hands the final partial
// block (state + in-block byte count) to the suffix padder.
// Optional build macro: KECCAK_ABSORB_KEEP_CHECK_EN enables the sticky
// protocol error flag err_o; otherwise err_o is tied low.
module keccak_absorb_unit
    import keccak_pkg::*;
#(
    parameter int IN_WIDTH       = 64,
    parameter int KEEP_WIDTH     = 8,
    parameter int MAX_RATE_BYTES = 168
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start_i,
    input  logic [RATE_WIDTH-1:0]                            rate_i,
    input  logic                                             msg_valid_i,
    output logic                                             msg_ready_o,
    input  logic [IN_WIDTH-1:0]                              msg_data_i,
    input  logic [KEEP_WIDTH-1:0]                            msg_keep_i,
    input  logic                                             msg_last_i,
    output logic                                             perm_start_o,
    input  logic                                             perm_done_i,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_o,
    output logic                                             pad_valid_o,
    input  logic                                             pad_ready_i,
    output logic [BYTE_ABSORB_WIDTH-1:0]                     bytes_absorbed_o,
    output logic                                             err_o
);

    // Wide enough for the last in-block count plus one full beat.
    localparam int CNT_W = $clog2(MAX_RATE_BYTES + KEEP_WIDTH + 1);

    absorb_state_e fsm_q, fsm_d;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_q, state_d, xor_state;
    logic [BYTE_ABSORB_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0]        rate_q, rate_d;
    logic                         pending_last_q, pending_last_d;
    logic                         perm_start_q, perm_start_d;
    logic [CNT_W-1:0]             cnt_sum;
    logic                         beat_fire;
    logic                         block_full;

    keccak_lane_xor u_lane_xor (
        .state_i    (state_q),
        .lane_idx_i (cnt_q[BYTE_ABSORB_WIDTH-1:3]),
        .data_i     (msg_data_i),
        .keep_i     (msg_keep_i),
        .state_o    (xor_state)
    );

    // Beat handshake and block-fill detection (byte count * 8 against rate in bits).
    always_comb begin
        msg_ready_o = (fsm_q == ABSORB);
        beat_fire   = msg_valid_i && msg_ready_o;
        cnt_sum     = CNT_W'(cnt_q) + CNT_W'(keep_popcount(msg_keep_i));
        block_full  = (32'({cnt_sum, 3'b000}) == 32'(rate_q));
    end

    // Next-state logic for the absorb FSM and its datapath registers.
    always_comb begin
        fsm_d          = fsm_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        rate_d         = rate_q;
        pending_last_d = pending_last_q;
        perm_start_d   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d        = '0;
                    cnt_d          = '0;
                    rate_d         = rate_i;
                    pending_last_d = 1'b0;
                    fsm_d          = ABSORB;
                end
            end
            ABSORB: begin
                if (beat_fire) begin
                    state_d = xor_state;
                    if (block_full) begin
                        cnt_d          = '0;
                        perm_start_d   = 1'b1;
                        pending_last_d = msg_last_i;
                        fsm_d          = PERM_WAIT;
                    end else begin
                        cnt_d = BYTE_ABSORB_WIDTH'(cnt_sum);
                        if (msg_last_i) begin
                            fsm_d = PAD_HOLD;
                        end
                    end
                end
            end
            PERM_WAIT: begin
                if (perm_done_i) begin
                    state_d = state_array_i;
                    if (pending_last_q) begin
                        // Message ended exactly on a block edge: pad into a fresh block.
                        cnt_d = '0;
                        fsm_d = PAD_HOLD;
                    end else begin
                        fsm_d = ABSORB;
                    end
                end
            end
            PAD_HOLD: begin
                if (pad_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= IDLE;
            state_q        <= '0;
            cnt_q          <= '0;
            rate_q         <= '0;
            pending_last_q <= 1'b0;
            perm_start_q   <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rate_q         <= rate_d;
            pending_last_q <= pending_last_d;
            perm_start_q   <= perm_start_d;
        end
    end

    assign perm_start_o     = perm_start_q;
    assign state_array_o    = state_q;
    assign pad_valid_o      = (fsm_q == PAD_HOLD);
    assign bytes_absorbed_o = cnt_q;

`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
    logic err_q, err_d;
    logic keep_bad, rate_bad;

    // Sticky protocol error: bad rate at start, or malformed keep on an accepted beat.
    always_comb begin
        keep_bad = ((msg_keep_i & (msg_keep_i + KEEP_WIDTH'(1))) != '0) ||
                   ((msg_keep_i != '1) && !msg_last_i);
        rate_bad = (rate_i[5:0] != 6'd0) || (32'(rate_i) > 32'(MAX_RATE_BYTES * 8));
        err_d    = err_q;
        if ((fsm_q == IDLE) && start_i) begin
            err_d = rate_bad;
        end else if (beat_fire && keep_bad) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_absorb_unit.sv
// Scoreboard bench for keccak_absorb_unit: a byte-level sponge-absorb model
// predicts every permutation request and padding hand-off.
module tb_keccak_absorb_unit;
    import keccak_pkg::*;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] st_t;
    typedef struct {
        bit  is_pad;
        st_t st;
        int  nbytes;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [RATE_WIDTH-1:0] rate_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [63:0] msg_data_i;
    logic [7:0]  msg_keep_i;
    logic        msg_last_i;
    logic        perm_start_o;
    logic        perm_done_i;
    st_t         state_array_i;
    st_t         state_array_o;
    logic        pad_valid_o;
    logic        pad_ready_i;
    logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_o;
    logic        err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    st_t  resp_q[$];
    bit   hold_perm = 0;
    bit   mon_off   = 0;
    bit   use_a5    = 0;
    int   rates[5]  = '{1088, 1344, 1152, 832, 576};

    keccak_absorb_unit dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .rate_i           (rate_i),
        .msg_valid_i      (msg_valid_i),
        .msg_ready_o      (msg_ready_o),
        .msg_data_i       (msg_data_i),
        .msg_keep_i       (msg_keep_i),
        .msg_last_i       (msg_last_i),
        .perm_start_o     (perm_start_o),
        .perm_done_i      (perm_done_i),
        .state_array_i    (state_array_i),
        .state_array_o    (state_array_o),
        .pad_valid_o      (pad_valid_o),
        .pad_ready_i      (pad_ready_i),
        .bytes_absorbed_o (bytes_absorbed_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk_state(string name, st_t act, st_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int y = 0; y < COL_SIZE; y++) begin
                for (int x = 0; x < ROW_SIZE; x++) begin
                    if (act[x][y] !== exp[x][y]) begin
                        $display("FAIL %s: lane[%0d][%0d] got %h expected %h",
                                 name, x, y, act[x][y], exp[x][y]);
                        return;
                    end
                end
            end
        end
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int x = 0; x < ROW_SIZE; x++)
            for (int y = 0; y < COL_SIZE; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    // Sponge absorb reference: message bytes land at consecutive block
    // positions; a full block yields a permutation with a fresh random result.
    task automatic model_msg(input byte unsigned msg[$], input int rate, input bit with_last);
        st_t  m;
        st_t  r;
        exp_t e;
        int   pos;
        int   lane;
        int   rb;
        m   = '0;
        pos = 0;
        rb  = rate / 8;
        foreach (msg[i]) begin
            lane = pos / 8;
            m[lane % 5][lane / 5][8*(pos % 8) +: 8] ^= msg[i];
            pos++;
            if (pos == rb) begin
                e.is_pad = 0; e.st = m; e.nbytes = 0;
                exp_q.push_back(e);
                if (use_a5) r = {25{64'hA5A5_A5A5_A5A5_A5A5}};
                else        r = rand_state();
                resp_q.push_back(r);
                m   = r;
                pos = 0;
            end
        end
        if (with_last) begin
            e.is_pad = 1; e.st = m; e.nbytes = pos;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int rate);
        @(posedge clk); #1;
        start_i = 1'b1;
        rate_i  = RATE_WIDTH'(rate);
        @(posedge clk); #1;
        start_i = 1'b0;
        rate_i  = RATE_WIDTH'($urandom);
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep,
                             input bit last, input bit inject_start);
        int t;
        msg_valid_i = 1'b1;
        msg_data_i  = data;
        msg_keep_i  = keep;
        msg_last_i  = last;
        if (inject_start) begin
            start_i = 1'b1;
            rate_i  = RATE_WIDTH'($urandom);
        end
        t = 0;
        @(negedge clk);
        while (!msg_ready_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!msg_ready_o) begin
            n_checks++; n_errors++;
            $display("FAIL beat_accept_timeout: ready=%0d required 1", msg_ready_o);
        end
        @(posedge clk); #1;
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic drive_msg(input byte unsigned msg[$], input int rate,
                             input bit with_last, input bit extra_empty);
        int len, n, rem;
        logic [63:0] d;
        logic [7:0]  k;
        len = msg.size();
        n   = (len + 7) / 8;
        if (len == 0 || extra_empty) n++;
        do_start(rate);
        for (int b = 0; b < n; b++) begin
            rem = len - 8*b;
            for (int j = 0; j < 8; j++)
                d[8*j +: 8] = (j < rem) ? msg[8*b + j] : 8'($urandom);
            if (rem >= 8)     k = 8'hFF;
            else if (rem > 0) k = 8'((9'd1 << rem) - 9'd1);
            else              k = 8'h00;
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
            send_beat(d, k, with_last && (b == n - 1), b == 1);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_msg(input string name, input byte unsigned msg[$],
                           input int rate, input bit extra_empty);
        model_msg(msg, rate, 1'b1);
        drive_msg(msg, rate, 1'b1, extra_empty);
        wait_drain(name);
        chk({name, "_idle_ready"}, 64'(msg_ready_o), 64'd0);
        chk({name, "_idle_pad"}, 64'(pad_valid_o), 64'd0);
    endtask

    // Scoreboard monitor: every permutation request and padding hand-off
    // must match the next predicted event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && !mon_off) begin
            if (perm_start_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL perm_unexpected: perm_start_o=1 required no request");
                end else begin
                    e = exp_q.pop_front();
                    chk("perm_kind_is_pad", 64'(e.is_pad), 64'd0);
                    chk_state("perm_state", state_array_o, e.st);
                end
            end
            if (pad_valid_o && pad_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL pad_unexpected: pad_valid_o=1 required no hand-off");
                end else begin
                    e = exp_q.pop_front();
                    chk("pad_kind_is_pad", 64'(e.is_pad), 64'd1);
                    chk_state("pad_state", state_array_o, e.st);
                    chk("pad_bytes", 64'(bytes_absorbed_o), 64'(e.nbytes));
                    chk("pad_err", 64'(err_o), 64'd0);
                end
            end
        end
    end

    // Permutation core stand-in: answers each request after a random delay.
    initial begin : perm_core
        perm_done_i   = 1'b0;
        state_array_i = '0;
        forever begin
            @(negedge clk);
            if (perm_start_o && !hold_perm && !rst) begin
                @(posedge clk);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                if (resp_q.size() > 0) begin
                    state_array_i = resp_q.pop_front();
                    perm_done_i   = 1'b1;
                    @(posedge clk); #1;
                    perm_done_i   = 1'b0;
                    state_array_i = rand_state();
                end
            end
        end
    end

    // Padder stand-in: random backpressure on the hand-off.
    initial begin : padder
        pad_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            pad_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : main
        byte unsigned msg[$];
        int len, rate;
        bit extra;
        rst         = 1'b1;
        start_i     = 1'b0;
        rate_i      = '0;
        msg_valid_i = 1'b0;
        msg_data_i  = '0;
        msg_keep_i  = '0;
        msg_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(msg_ready_o), 64'd0);
        chk("rst_perm_start", 64'(perm_start_o), 64'd0);
        chk("rst_pad_valid", 64'(pad_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_bytes", 64'(bytes_absorbed_o), 64'd0);
        chk_state("rst_state", state_array_o, '0);
        rst = 1'b0;

        // Eight 0x11 bytes then a single 0x22 byte at SHA3-256 rate.
        msg.delete();
        repeat (8) msg.push_back(8'h11);
        msg.push_back(8'h22);
        run_msg("sha3_256_nine_bytes", msg, 1088, 1'b0);

        // Exactly one SHA3-256 block, permutation returns all 0xA5.
        msg.delete();
        repeat (136) msg.push_back(8'($urandom));
        use_a5 = 1;
        run_msg("sha3_256_exact_block", msg, 1088, 1'b0);
        use_a5 = 0;

        // SHAKE128: 21 full beats then one more full last beat.
        msg.delete();
        repeat (176) msg.push_back(8'($urandom));
        run_msg("shake128_block_plus_lane", msg, 1344, 1'b0);

        // Empty message.
        msg.delete();
        run_msg("empty_msg", msg, 1088, 1'b0);

        // Block filled exactly, then an empty last beat.
        msg.delete();
        repeat (72) msg.push_back(8'($urandom));
        run_msg("exact_fill_empty_last", msg, 576, 1'b1);

        // Random messages at random rates.
        for (int i = 0; i < 25; i++) begin
            msg.delete();
            len  = $urandom_range(0, 400);
            rate = rates[$urandom_range(0, 4)];
            repeat (len) msg.push_back(8'($urandom));
            extra = (len > 0) && (len % 8 == 0) && ($urandom_range(0, 1) == 1);
            run_msg("random_msg", msg, rate, extra);
        end

        // Reset while waiting on a permutation, with a beat held at the input.
        hold_perm = 1;
        msg.delete();
        repeat (136) msg.push_back(8'($urandom));
        model_msg(msg, 1088, 1'b0);
        drive_msg(msg, 1088, 1'b0, 1'b0);
        wait_drain("perm_wait_setup");
        msg_valid_i = 1'b1;
        msg_data_i  = {$urandom, $urandom};
        msg_keep_i  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("perm_wait_backpressure", 64'(msg_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(msg_ready_o), 64'd0);
        chk("midrst_perm_start", 64'(perm_start_o), 64'd0);
        chk("midrst_pad_valid", 64'(pad_valid_o), 64'd0);
        chk("midrst_err", 64'(err_o), 64'd0);
        chk("midrst_bytes", 64'(bytes_absorbed_o), 64'd0);
        chk_state("midrst_state", state_array_o, '0);
        rst         = 1'b0;
        msg_valid_i = 1'b0;
        resp_q.delete();
        hold_perm   = 0;

        // Held beat must have been dropped: a fresh empty message pads with zero state.
        msg.delete();
        run_msg("post_reset_empty", msg, 1088, 1'b0);

`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
        begin : keep_check
            logic [63:0] d;
            int t;
            mon_off = 1;
            do_start(1088);
            d = {$urandom, $urandom};
            send_beat(d, 8'h05, 1'b1, 1'b0);
            @(negedge clk);
            chk("keep05_err", 64'(err_o), 64'd1);
            chk("keep05_bytes", 64'(bytes_absorbed_o), 64'd2);
            chk("keep05_lane", state_array_o[0][0], d & 64'h0000_0000_00FF_00FF);
            t = 0;
            while (pad_valid_o && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            chk("keep05_idle", 64'(pad_valid_o), 64'd0);
            chk("keep05_err_sticky", 64'(err_o), 64'd1);
            do_start(1088);
            chk("start_clears_err", 64'(err_o), 64'd0);
            send_beat(64'd0, 8'h00, 1'b1, 1'b0);
            t = 0;
            while (!pad_valid_o && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            while (pad_valid_o && t < 250) begin
                @(posedge clk); #1;
                t++;
            end
            chk("keep_check_return_idle", 64'(pad_valid_o), 64'd0);
            mon_off = 0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
